// File: rtl/seg7_scan_if.sv
// Scanned 4-digit 7-segment bus plus the decoded-frame outputs of its monitor.
// master: the side driving the scan (display driver / bench).
// slave : the decoder that samples the scan and publishes frames.
interface seg7_scan_if;
  logic [3:0] s;
  logic [6:0] seg;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;
  logic       frame_valid;
  logic       err;

  modport master (output s, seg, input d1, d2, d3, d4, frame_valid, err);
  modport slave  (input s, seg, output d1, d2, d3, d4, frame_valid, err);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment display.
// Synchronizes the scanned (s, seg) pair, waits for it to be stable, decodes
// the glyph and assembles digits 1..4 into a frame published atomically.
//
// state | meaning
// SYNC  | waiting for a settled digit1 to start a frame
// EXP2  | digit1 captured, expecting digit2
// EXP3  | digits 1-2 captured, expecting digit3
// EXP4  | digits 1-3 captured, expecting digit4
module seg7_scan_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, EXP2, EXP3, EXP4} state_t;

  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic [10:0]  pair, prev;
  logic [3:0]   ss;
  logic [6:0]   sseg;
  logic [CW-1:0] cnt;
  logic         settle;
  logic [3:0]   code;
  logic         known, onehot;

  state_t     state, state_n;
  logic [3:0] h1, h2, h3, h1_n, h2_n, h3_n;
  logic [3:0] last_sel, last_sel_n;
  logic [3:0] d1, d2, d3, d4, d1_n, d2_n, d3_n, d4_n;
  logic       fv, fv_n, err, err_n;

  assign pair = sync_q[SYNC_STAGES-1];
  assign ss   = pair[10:7];
  assign sseg = pair[6:0];

  // Input synchronizer chain for the whole (s, seg) pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {bus.s, bus.seg};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Stability filter; the counter starts saturated so an idle bus after reset
  // never produces a settle (and thus no spurious err on s=0000).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      cnt  <= CW'(STABLE_CYCLES);
    end else begin
      prev <= pair;
      if (pair != prev)                    cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES))  cnt <= cnt + 1'b1;
    end
  end

  assign settle = (pair == prev) && (cnt == CW'(STABLE_CYCLES - 1));
  assign onehot = (ss != 4'b0000) && ((ss & (ss - 4'd1)) == 4'b0000);

  // Glyph decode, segments ordered g..a.
  always_comb begin
    known = 1'b1;
    code  = 4'h0;
    case (sseg)
      7'b0111111: code = 4'h0;
      7'b0000110: code = 4'h1;
      7'b1011011: code = 4'h2;
      7'b1001111: code = 4'h3;
      7'b1100110: code = 4'h4;
      7'b1101101: code = 4'h5;
      7'b1111101: code = 4'h6;
      7'b0000111: code = 4'h7;
      7'b1111111: code = 4'h8;
      7'b1101111: code = 4'h9;
      7'b1110111: code = 4'hA;
      7'b1111100: code = 4'hB;
      7'b0111001: code = 4'hC;
      7'b1011110: code = 4'hD;
      7'b1111001: code = 4'hE;
      7'b1110001: code = 4'hF;
      default:    known = 1'b0;
    endcase
  end

  // Frame assembly: all actions are taken only on a settle.
  always_comb begin
    state_n    = state;
    h1_n       = h1;
    h2_n       = h2;
    h3_n       = h3;
    last_sel_n = last_sel;
    d1_n       = d1;
    d2_n       = d2;
    d3_n       = d3;
    d4_n       = d4;
    fv_n       = 1'b0;
    err_n      = 1'b0;
    if (settle) begin
      if (!onehot || !known) begin
        err_n   = 1'b1;
        state_n = SYNC;
      end else if (ss == 4'b0001) begin
        h1_n       = code;
        last_sel_n = ss;
        state_n    = EXP2;
        err_n      = (state == EXP3) || (state == EXP4);
      end else if (state != SYNC && ss == last_sel) begin
        // Same digit re-settled with new segments: refresh its shadow only.
        if (ss == 4'b0010) h2_n = code;
        else               h3_n = code;
      end else if (state == EXP2 && ss == 4'b0010) begin
        h2_n       = code;
        last_sel_n = ss;
        state_n    = EXP3;
      end else if (state == EXP3 && ss == 4'b0100) begin
        h3_n       = code;
        last_sel_n = ss;
        state_n    = EXP4;
      end else if (state == EXP4 && ss == 4'b1000) begin
        d1_n    = h1;
        d2_n    = h2;
        d3_n    = h3;
        d4_n    = code;
        fv_n    = 1'b1;
        state_n = SYNC;
      end else begin
        err_n   = (state != SYNC);
        state_n = SYNC;
      end
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SYNC;
      h1       <= '0;
      h2       <= '0;
      h3       <= '0;
      last_sel <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      d4       <= '0;
      fv       <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      h1       <= h1_n;
      h2       <= h2_n;
      h3       <= h3_n;
      last_sel <= last_sel_n;
      d1       <= d1_n;
      d2       <= d2_n;
      d3       <= d3_n;
      d4       <= d4_n;
      fv       <= fv_n;
      err      <= err_n;
    end
  end

  assign bus.d1          = d1;
  assign bus.d2          = d2;
  assign bus.d3          = d3;
  assign bus.d4          = d4;
  assign bus.frame_valid = fv;
  assign bus.err         = err;
endmodule
